// File: rtl/cache_pkg.sv
// Shared encodings and geometry helpers for the direct-mapped parameterised cache.
package cache_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOOKUP    = 2'd1;
  localparam logic [1:0] ST_WRITEBACK = 2'd2;
  localparam logic [1:0] ST_REFILL    = 2'd3;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines);
    return addr_w - $clog2(lines);
  endfunction

endpackage

// File: rtl/cache_array.sv
// Line storage: valid/dirty bits (cleared on reset) plus tag and data arrays,
// read asynchronously and written through one port with per-field enables.
module cache_array
  import cache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int TAG_W  = 12,
  parameter int DATA_W = 32,
  parameter int IDX_W  = idx_w(LINES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic              we_valid_i,
  input  logic              we_dirty_i,
  input  logic              we_tag_i,
  input  logic              we_data_i,
  input  logic              wr_valid_i,
  input  logic              wr_dirty_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (we_valid_i) valid_q[wr_idx_i] <= wr_valid_i;
      if (we_dirty_i) dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

  // Tag and data carry no reset; a cleared valid bit makes their contents irrelevant.
  always_ff @(posedge clk_i) begin
    if (we_tag_i)  tag_q[wr_idx_i]  <= wr_tag_i;
    if (we_data_i) data_q[wr_idx_i] <= wr_data_i;
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/param_cache.sv
// Direct-mapped write-back, write-allocate cache with one-word lines,
// dirty-line writeback and saturating hit/miss counters.
module param_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]        state_q, state_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [CNT_W-1:0]  miss_q, miss_d;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              line_valid, line_dirty, hit;
  logic [TAG_W-1:0]  line_tag;
  logic [DATA_W-1:0] line_data;
  logic              we_valid, we_dirty, we_tag, we_data;
  logic              wr_valid, wr_dirty;
  logic [TAG_W-1:0]  wr_tag;
  logic [DATA_W-1:0] wr_data;

  assign req_idx = addr_q[IDX_W-1:0];
  assign req_tag = addr_q[ADDR_W-1:IDX_W];
  assign hit     = line_valid && (line_tag == req_tag);

  cache_array #(
    .LINES (LINES),
    .TAG_W (TAG_W),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i     (clk),
    .rst_i     (rst),
    .rd_idx_i  (req_idx),
    .rd_valid_o(line_valid),
    .rd_dirty_o(line_dirty),
    .rd_tag_o  (line_tag),
    .rd_data_o (line_data),
    .wr_idx_i  (req_idx),
    .we_valid_i(we_valid),
    .we_dirty_i(we_dirty),
    .we_tag_i  (we_tag),
    .we_data_i (we_data),
    .wr_valid_i(wr_valid),
    .wr_dirty_i(wr_dirty),
    .wr_tag_i  (wr_tag),
    .wr_data_i (wr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // mem_read/mem_write are valid strobes held until mem_ack (ready); a transfer
  // completes on the edge where both are high, and that same edge drops the strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (cpu_read || cpu_write) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (hit)                           state_d = ST_IDLE;
        else if (line_valid && line_dirty) state_d = ST_WRITEBACK;
        else                               state_d = ST_REFILL;
      end
      ST_WRITEBACK: if (mem_ack) state_d = ST_REFILL;
      ST_REFILL:    if (mem_ack) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_busy  = (state_q != ST_IDLE);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    we_valid  = 1'b0;
    we_dirty  = 1'b0;
    we_tag    = 1'b0;
    we_data   = 1'b0;
    wr_valid  = 1'b0;
    wr_dirty  = 1'b0;
    wr_tag    = req_tag;
    wr_data   = wdata_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    hit_d     = hit_q;
    miss_d    = miss_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_read || cpu_write) begin
          op_d    = cpu_write ? OP_WRITE : OP_READ;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          done_d = 1'b1;
          hit_d  = (&hit_q) ? hit_q : hit_q + CNT_ONE;
          if (op_q == OP_WRITE) begin
            we_data  = 1'b1;
            we_dirty = 1'b1;
            wr_dirty = 1'b1;
          end else begin
            rdata_d = line_data;
          end
        end else begin
          miss_d = (&miss_q) ? miss_q : miss_q + CNT_ONE;
        end
      end
      ST_WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {line_tag, req_idx};
        mem_wdata = line_data;
      end
      ST_REFILL: begin
        mem_read = 1'b1;
        mem_addr = addr_q;
        if (mem_ack) begin
          we_valid = 1'b1;
          we_dirty = 1'b1;
          we_tag   = 1'b1;
          we_data  = 1'b1;
          wr_valid = 1'b1;
          wr_dirty = (op_q == OP_WRITE);
          // A write miss merges its own word over the fill data.
          wr_data  = (op_q == OP_WRITE) ? wdata_q : mem_rdata;
          done_d   = 1'b1;
          if (op_q == OP_READ) rdata_d = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_done   = done_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_param_cache.sv
// Bench for param_cache: directed scenarios plus random traffic against a
// line-level cache model and a backing-memory responder with variable ack delay.
module tb_param_cache;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int LN   = 16;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_read, cpu_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_done, cpu_busy;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic [CW-1:0] hit_count, miss_count;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  param_cache #(.ADDR_W(AW), .DATA_W(DW), .LINES(LN), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .cpu_busy  (cpu_busy),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_count (hit_count),
    .miss_count(miss_count),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit            is_read;
    logic [DW-1:0] rdata;
    int            hits;
    int            misses;
  } done_t;

  typedef struct {
    bit            is_write;
    int            addr;
    logic [DW-1:0] data;
  } mtx_t;

  done_t exp_q[$];
  mtx_t  mem_exp_q[$];

  bit            m_valid [LN];
  bit            m_dirty [LN];
  int            m_tag   [LN];
  logic [DW-1:0] m_data  [LN];
  int            m_hits, m_misses;
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] bk_mem  [int];

  function automatic logic [DW-1:0] mem_init(input int a);
    return {16'hAAAA, a[15:0]};
  endfunction

  function automatic logic [DW-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  function automatic logic [DW-1:0] bk_rd(input int a);
    return bk_mem.exists(a) ? bk_mem[a] : mem_init(a);
  endfunction

  // kind: 0 hit, 1 clean miss, 2 dirty miss
  task automatic predict(input bit w, input int a, input logic [DW-1:0] wd, output int kind);
    int    idx;
    int    tg;
    done_t d;
    mtx_t  t;
    idx = a % LN;
    tg  = a / LN;
    if (m_valid[idx] && m_tag[idx] == tg) begin
      kind = 0;
      if (m_hits < CMAX) m_hits++;
      if (w) begin
        m_data[idx]  = wd;
        m_dirty[idx] = 1'b1;
      end
    end else begin
      kind = (m_valid[idx] && m_dirty[idx]) ? 2 : 1;
      if (m_misses < CMAX) m_misses++;
      if (kind == 2) begin
        t.is_write = 1'b1;
        t.addr     = m_tag[idx] * LN + idx;
        t.data     = m_data[idx];
        mem_exp_q.push_back(t);
        ref_mem[t.addr] = m_data[idx];
      end
      t.is_write = 1'b0;
      t.addr     = a;
      t.data     = '0;
      mem_exp_q.push_back(t);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = w;
      m_data[idx]  = w ? wd : ref_rd(a);
    end
    d.is_read = !w;
    d.rdata   = m_data[idx];
    d.hits    = m_hits;
    d.misses  = m_misses;
    exp_q.push_back(d);
  endtask

  task automatic model_reset();
    for (int i = 0; i < LN; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
    exp_q.delete();
    mem_exp_q.delete();
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : compare
    done_t d;
    if (!rst && cpu_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        d = exp_q.pop_front();
        if (d.is_read) chk("rdata", cpu_rdata, d.rdata);
        chk("hit_count", hit_count, d.hits);
        chk("miss_count", miss_count, d.misses);
      end
    end
  end

  // ---------------- memory responder ----------------
  int            ack_delay = 0;
  bit            inject_ack = 1'b0;
  bit            in_txn = 1'b0;
  bit            cur_w;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  int            wait_cnt;
  logic [AW-1:0] last_rd_addr, last_wr_addr;
  logic [DW-1:0] last_wr_data, last_rdata;

  initial begin : responder
    mtx_t t;
    mem_ack   = 1'b0;
    mem_rdata = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        if (in_txn && cur_w) bk_mem[int'(cur_addr)] = cur_data;
        mem_ack   = 1'b0;
        in_txn    = 1'b0;
        mem_rdata = 32'hDEADBEEF;
      end
      if (rst) begin
        in_txn = 1'b0;
      end else begin
        if (mem_read || mem_write) chk("strobe_overlap", mem_read && mem_write, 0);
        if (in_txn && !(mem_read || mem_write)) in_txn = 1'b0;
        if (!in_txn && (mem_read || mem_write)) begin
          if (mem_exp_q.size() == 0) begin
            chk("mem_unexpected", 1, 0);
          end else begin
            t = mem_exp_q.pop_front();
            chk("mem_kind", mem_write, t.is_write);
            chk("mem_addr", mem_addr, t.addr);
            if (t.is_write) chk("mem_wdata", mem_wdata, t.data);
          end
          cur_w    = mem_write;
          cur_addr = mem_addr;
          cur_data = mem_wdata;
          wait_cnt = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
          in_txn   = 1'b1;
          if (mem_write) begin
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
          end else begin
            last_rd_addr = mem_addr;
          end
        end else if (in_txn) begin
          chk("mem_addr_stable", mem_addr, cur_addr);
        end
        if (in_txn) begin
          if (wait_cnt == 0) begin
            mem_ack = 1'b1;
            if (!cur_w) mem_rdata = bk_rd(int'(cur_addr));
          end else begin
            wait_cnt--;
          end
        end else if (inject_ack) begin
          mem_ack    = 1'b1;
          inject_ack = 1'b0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input bit w, input int a, input logic [DW-1:0] wd);
    int kind;
    int lat;
    @(negedge clk);
    cpu_read  = !w;
    cpu_write = w;
    cpu_addr  = a[AW-1:0];
    cpu_wdata = wd;
    predict(w, a, wd, kind);
    @(negedge clk);
    lat = 1;
    while (!cpu_done && lat < 80) begin
      chk("busy_in_flight", cpu_busy, 1);
      cpu_read  = 1'($urandom_range(0, 1));
      cpu_write = 1'($urandom_range(0, 1));
      cpu_addr  = AW'($urandom_range(0, 65535));
      cpu_wdata = $urandom;
      @(negedge clk);
      lat++;
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    if (!cpu_done) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("busy_at_done", cpu_busy, 0);
      if (kind == 0)           chk("hit_latency", lat, 2);
      else if (ack_delay == 0) chk("miss_latency", lat, 2 + kind);
      else                     chk("miss_latency_min", lat >= 3, 1);
      last_rdata = cpu_rdata;
    end
  endtask

  initial begin : main
    int kind;
    int n;
    int a;
    rst       = 1'b1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_done", cpu_done, 0);
    chk("rst_busy", cpu_busy, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;

    // zero-wait memory: clean read miss, then hit
    ack_delay = 0;
    do_req(1'b0, 'h0005, '0);
    chk("tp1_data", last_rdata, 32'hAAAA0005);
    chk("tp1_mem_addr", last_rd_addr, 16'h0005);
    chk("tp1_misses", miss_count, 1);
    do_req(1'b0, 'h0005, '0);
    chk("tp2_data", last_rdata, 32'hAAAA0005);
    chk("tp2_hits", hit_count, 1);

    // write-allocate miss followed by read hit
    do_req(1'b1, 'h0000, 32'h0000FFFF);
    do_req(1'b0, 'h0000, '0);
    chk("tp3_data", last_rdata, 32'h0000FFFF);
    chk("tp3_hits", hit_count, 2);

    // dirty eviction with slow memory
    ack_delay = 3;
    do_req(1'b0, 'h0010, '0);
    chk("tp4_wb_addr", last_wr_addr, 16'h0000);
    chk("tp4_wb_data", last_wr_data, 32'h0000FFFF);
    chk("tp4_rd_addr", last_rd_addr, 16'h0010);
    chk("tp4_data", last_rdata, 32'hAAAA0010);
    chk("tp4_misses", miss_count, 3);

    // five hits in total: counter pinned at its maximum
    repeat (3) do_req(1'b0, 'h0010, '0);
    chk("tp6_hits_sat", hit_count, 3);

    // reset while refilling 0x0020
    @(negedge clk);
    cpu_read = 1'b1;
    cpu_addr = 16'h0020;
    predict(1'b0, 'h0020, '0, kind);
    @(negedge clk);
    cpu_read = 1'b0;
    n = 0;
    while (!mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_refill_seen", mem_read, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_mem_read", mem_read, 0);
    chk("abort_mem_write", mem_write, 0);
    chk("abort_done", cpu_done, 0);
    chk("abort_busy", cpu_busy, 0);
    chk("abort_hits", hit_count, 0);
    chk("abort_misses", miss_count, 0);
    rst = 1'b0;
    model_reset();
    inject_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_ack_busy", cpu_busy, 0);
      chk("stray_ack_done", cpu_done, 0);
    end

    // valid bits were cleared, so this misses and sees the written-back word
    ack_delay = 0;
    do_req(1'b0, 'h0000, '0);
    chk("tp5_misses", miss_count, 1);
    chk("tp5_hits", hit_count, 0);
    chk("tp5_rd_addr", last_rd_addr, 16'h0000);
    chk("tp5_data", last_rdata, 32'h0000FFFF);

    // random traffic with random ack delays
    ack_delay = -1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) a = int'($urandom_range(0, 65535));
      else a = int'($urandom_range(0, 3)) * LN + int'($urandom_range(0, LN - 1));
      do_req(1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("mem_exp_q_drained", mem_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
